dmem_responder: RTL and testbench

- Data-memory responder serving the MEM-stage load/store port of the pipelined CPU.
- Accepts a read or write request, holds the pipeline via stall_o for a fixed access latency, then completes with a one-cycle ack_o and registered read data.
- Replaces the zero-latency combinational data memory so the core can be run against realistic memory timing.
- Owns a word-addressed storage array and flags bad accesses with err_o.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage and the data-memory responder.
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic [31:0] memdata;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (
    output memread, memwrite, memaddr, writedata,
    input  memdata, ack, stall, err
  );

  modport slave (
    input  memread, memwrite, memaddr, writedata,
    output memdata, ack, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the pipeline for LATENCY cycles,
// then completes with a one-cycle ack and registered read data.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CW    = 4;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept, stall_c, enter_done;
  logic            req, req_err;
  logic            cap_wr, cap_err;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic            fin_wr, fin_err;
  logic [AW-1:0]   fin_idx;
  logic [31:0]     fin_wdata;
  logic            ack_q, err_q;
  logic [31:0]     memdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  assign req     = bus.memread | bus.memwrite;
  assign req_err = (bus.memaddr[1:0] != 2'b00) | (bus.memaddr >= LIMIT) |
                   (bus.memread & bus.memwrite);

  // Next-state, counter and stall decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    stall_c = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          stall_c = 1'b1;
          if (LATENCY == 1) begin
            state_n = DONE;
          end else begin
            state_n = BUSY;
            cnt_n   = CW'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With LATENCY=1 the transaction completes on its accepting edge, so the live inputs are used
  always_comb begin
    enter_done = (state_n == DONE);
    if (state == IDLE) begin
      fin_wr    = bus.memwrite;
      fin_err   = req_err;
      fin_idx   = bus.memaddr[AW+1:2];
      fin_wdata = bus.writedata;
    end else begin
      fin_wr    = cap_wr;
      fin_err   = cap_err;
      fin_idx   = cap_idx;
      fin_wdata = cap_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      memdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        cap_wr    <= bus.memwrite;
        cap_err   <= req_err;
        cap_idx   <= bus.memaddr[AW+1:2];
        cap_wdata <= bus.writedata;
      end
      ack_q <= enter_done;
      err_q <= enter_done & fin_err;
      if (enter_done) begin
        if (fin_err)     memdata_q <= '0;
        else if (!fin_wr) memdata_q <= mem[fin_idx];
      end
    end
  end

  // Storage survives reset; a write caught by reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && enter_done && fin_wr && !fin_err) mem[fin_idx] <= fin_wdata;
  end

  assign bus.memdata = memdata_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.stall   = stall_c;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: a LATENCY=4 and a LATENCY=1 instance
// checked against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_responder_if bus4 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: one word array per instance plus the last value seen on memdata
  logic [31:0] ref_mem [2][DEPTH];
  bit          ref_known [2][DEPTH];
  logic [31:0] ref_last [2];
  bit          ref_last_known [2];

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  task automatic model(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, output bit e_err, output bit d_known,
                       output logic [31:0] e_data);
    int idx;
    e_err = (a % 4 != 0) || (a >= 4 * DEPTH) || (rd && wr);
    idx   = int'(a / 4) % DEPTH;
    if (e_err) begin
      ref_last[sel]       = 32'h0;
      ref_last_known[sel] = 1'b1;
    end else if (wr) begin
      ref_mem[sel][idx]   = d;
      ref_known[sel][idx] = 1'b1;
    end else begin
      ref_last[sel]       = ref_mem[sel][idx];
      ref_last_known[sel] = ref_known[sel][idx];
    end
    e_data  = ref_last[sel];
    d_known = ref_last_known[sel];
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (sel == 1) begin
      bus1.memread = rd; bus1.memwrite = wr; bus1.memaddr = a; bus1.writedata = d;
    end else begin
      bus4.memread = rd; bus4.memwrite = wr; bus4.memaddr = a; bus4.writedata = d;
    end
  endtask

  // Issues one request in an idle cycle and records stall/ack/err per cycle, cycle 0 = request cycle
  task automatic run_txn(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [15:0] sb, output logic [15:0] ab,
                         output logic [15:0] eb, output logic [31:0] dd);
    int lat;
    lat = lat_of(sel);
    sb = '0; ab = '0; eb = '0; dd = '0;
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      sb[k] = (sel == 1) ? bus1.stall : bus4.stall;
      ab[k] = (sel == 1) ? bus1.ack   : bus4.ack;
      eb[k] = (sel == 1) ? bus1.err   : bus4.err;
      if (k == lat) dd = (sel == 1) ? bus1.memdata : bus4.memdata;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus4.ack !== 1'b0 || bus1.ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack got %b/%b want 0/0", bus4.ack, bus1.ack); end
    checks++; if (bus4.err !== 1'b0 || bus1.err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b/%b want 0/0", bus4.err, bus1.err); end
    checks++; if (bus4.memdata !== 32'h0 || bus1.memdata !== 32'h0) begin
      errors++; $display("FAIL reset_memdata got %h/%h want 0", bus4.memdata, bus1.memdata); end
    checks++; if (bus4.stall !== 1'b0 || bus1.stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b/%b want 0/0", bus4.stall, bus1.stall); end
  endtask

  task automatic test_write_latency();
    logic [15:0] sb, ab, eb; logic [31:0] dd, ed; bit ee, dk;
    model(0, 1'b0, 1'b1, 32'h08, 32'h12345678, ee, dk, ed);
    run_txn(0, 1'b0, 1'b1, 32'h08, 32'h12345678, sb, ab, eb, dd);
    checks++; if (sb !== 16'h000F) begin errors++; $display("FAIL wr_stall got %h want 000f", sb); end
    checks++; if (ab !== 16'h0010) begin errors++; $display("FAIL wr_ack got %h want 0010", ab); end
    checks++; if (eb !== 16'h0000) begin errors++; $display("FAIL wr_err got %h want 0000", eb); end
  endtask

  task automatic test_read_after_write();
    logic [15:0] sb, ab, eb; logic [31:0] dd, ed; bit ee, dk;
    model(0, 1'b1, 1'b0, 32'h08, 32'h0, ee, dk, ed);
    run_txn(0, 1'b1, 1'b0, 32'h08, 32'h0, sb, ab, eb, dd);
    checks++; if (ab !== 16'h0010) begin errors++; $display("FAIL raw_ack got %h want 0010", ab); end
    checks++; if (dd !== 32'h12345678) begin
      errors++; $display("FAIL raw_data got %h want 12345678", dd); end
    @(negedge clk); #1;
    checks++; if (bus4.ack !== 1'b0 || bus4.memdata !== ed) begin
      errors++; $display("FAIL raw_hold got ack=%b data=%h want ack=0 data=%h", bus4.ack, bus4.memdata, ed); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sb, ab, eb; logic [31:0] dd, ed, w0, w1; bit ee, dk;
    w0 = $urandom; w1 = $urandom;
    model(0, 1'b0, 1'b1, 32'h00, w0, ee, dk, ed);
    run_txn(0, 1'b0, 1'b1, 32'h00, w0, sb, ab, eb, dd);
    model(0, 1'b0, 1'b1, 32'h04, w1, ee, dk, ed);
    run_txn(0, 1'b0, 1'b1, 32'h04, w1, sb, ab, eb, dd);
    for (int i = 0; i < 2; i++) begin
      model(0, 1'b1, 1'b0, 32'(4 * i), 32'h0, ee, dk, ed);
      run_txn(0, 1'b1, 1'b0, 32'(4 * i), 32'h0, sb, ab, eb, dd);
      checks++; if (ab !== 16'h0010 || sb !== 16'h000F) begin
        errors++; $display("FAIL b2b_timing[%0d] got ack=%h stall=%h want 0010/000f", i, ab, sb); end
      checks++; if (dd !== ed) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, dd, ed); end
    end
    @(negedge clk); #1;
    checks++; if (bus4.ack !== 1'b0) begin errors++; $display("FAIL b2b_extra_ack got %b want 0", bus4.ack); end
  endtask

  task automatic test_errors();
    logic [15:0] sb, ab, eb; logic [31:0] dd, ed; logic [31:0] a [4]; bit r [4]; bit w [4]; bit ee, dk;
    a = '{32'h06, 32'h80, 32'h0C, 32'h00};
    r = '{1'b1, 1'b0, 1'b1, 1'b1};
    w = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      model(0, r[i], w[i], a[i], 32'hA5A5_0000 + 32'(i), ee, dk, ed);
      run_txn(0, r[i], w[i], a[i], 32'hA5A5_0000 + 32'(i), sb, ab, eb, dd);
      checks++; if (eb !== (ee ? 16'h0010 : 16'h0000) || ab !== 16'h0010) begin
        errors++; $display("FAIL err_flag[%0d] got err=%h ack=%h want err=%h", i, eb, ab, ee ? 16'h0010 : 16'h0); end
      checks++; if (dk && dd !== ed) begin errors++; $display("FAIL err_data[%0d] got %h want %h", i, dd, ed); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] sb, ab, eb; logic [31:0] dd, ed; bit ee, dk;
    model(0, 1'b0, 1'b1, 32'h10, 32'h0, ee, dk, ed);
    run_txn(0, 1'b0, 1'b1, 32'h10, 32'h0, sb, ab, eb, dd);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.ack !== 1'b0 || bus4.stall !== 1'b0 || bus4.memdata !== 32'h0) begin
      errors++; $display("FAIL rst_busy got ack=%b stall=%b data=%h want 0/0/0", bus4.ack, bus4.stall, bus4.memdata); end
    ref_last[0] = 32'h0; ref_last[1] = 32'h0;
    ref_last_known[0] = 1'b1; ref_last_known[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      checks++; if (bus4.ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack[%0d] got %b want 0", k, bus4.ack); end
    end
    model(0, 1'b1, 1'b0, 32'h10, 32'h0, ee, dk, ed);
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, sb, ab, eb, dd);
    checks++; if (dd !== 32'h0 || ab !== 16'h0010) begin
      errors++; $display("FAIL rst_no_commit got data=%h ack=%h want 00000000/0010", dd, ab); end
  endtask

  task automatic test_latency1();
    logic [15:0] sb, ab, eb; logic [31:0] dd, ed, w; bit ee, dk;
    w = $urandom;
    model(1, 1'b0, 1'b1, 32'h0C, w, ee, dk, ed);
    run_txn(1, 1'b0, 1'b1, 32'h0C, w, sb, ab, eb, dd);
    model(1, 1'b1, 1'b0, 32'h0C, 32'h0, ee, dk, ed);
    run_txn(1, 1'b1, 1'b0, 32'h0C, 32'h0, sb, ab, eb, dd);
    checks++; if (sb !== 16'h0001 || ab !== 16'h0002) begin
      errors++; $display("FAIL lat1_timing got stall=%h ack=%h want 0001/0002", sb, ab); end
    checks++; if (dd !== w) begin errors++; $display("FAIL lat1_data got %h want %h", dd, w); end
  endtask

  task automatic test_random(input int sel, input int n);
    logic [15:0] sb, ab, eb, xs, xa, xe; logic [31:0] dd, ed, a, d; bit ee, dk, r, w; int kind, lat;
    lat = lat_of(sel);
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 9));
      r = 1'($urandom_range(0, 1)); w = !r; d = $urandom;
      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      else if (kind == 1) a = a + 32'(4 * DEPTH) * 32'($urandom_range(1, 1000));
      else if (kind == 2) begin r = 1'b1; w = 1'b1; end
      model(sel, r, w, a, d, ee, dk, ed);
      run_txn(sel, r, w, a, d, sb, ab, eb, dd);
      xs = 16'((1 << lat) - 1);
      xa = 16'(1 << lat);
      xe = ee ? xa : 16'h0;
      checks++; if (sb !== xs || ab !== xa || eb !== xe) begin
        errors++; $display("FAIL rand%0d[%0d] a=%h got stall=%h ack=%h err=%h want %h/%h/%h",
                           sel, i, a, sb, ab, eb, xs, xa, xe); end
      if (dk) begin
        checks++; if (dd !== ed) begin errors++; $display("FAIL rand%0d_data[%0d] a=%h got %h want %h", sel, i, a, dd, ed); end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; checks = 0; errors = 0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      ref_last[s] = 32'h0; ref_last_known[s] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin ref_mem[s][i] = 32'h0; ref_known[s][i] = 1'b0; end
    end
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_write_latency();
    test_read_after_write();
    test_back_to_back();
    test_errors();
    test_reset_mid_busy();
    test_latency1();
    test_random(0, 60);
    test_random(1, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
